// File: rtl/host_cmd_frame_parser.sv
// Host command frame parser: assembles opcode/target/length/payload frames from the UART
// byte stream, holds each complete frame for the dispatcher and reports frame errors.
module host_cmd_frame_parser #(
    parameter int MAX_PAYLOAD    = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        cmd_valid,
    input  logic        cmd_ack,
    output logic [7:0]  cmd_opcode,
    output logic [47:0] cmd_target,
    output logic [7:0]  cmd_len,
    input  logic [7:0]  pl_addr,
    output logic [7:0]  pl_data,
    output logic        err_strobe,
    output logic [1:0]  err_code
);

    localparam int IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       MAX_LEN  = 8'(MAX_PAYLOAD);

    localparam logic [1:0] ERR_OVERSIZE = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_OVERRUN  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        TARGET,
        LENGTH,
        PAYLOAD,
        DRAIN,
        HOLD
    } state_t;

    state_t           state;
    logic [7:0]       byte_cnt;
    logic [7:0]       len;
    logic [7:0]       opcode;
    logic [47:0]      target;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       pl_buf [MAX_PAYLOAD];
    logic             active;
    logic             expire;

    // The inter-byte watchdog only runs while a frame is partially received.
    assign active = (state == TARGET) || (state == LENGTH) ||
                    (state == PAYLOAD) || (state == DRAIN);
    assign expire = active && (tmo_cnt == TMO_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            len        <= '0;
            opcode     <= '0;
            target     <= '0;
            tmo_cnt    <= '0;
            cmd_valid  <= 1'b0;
            cmd_opcode <= '0;
            cmd_target <= '0;
            cmd_len    <= '0;
            err_strobe <= 1'b0;
            err_code   <= '0;
        end else begin
            err_strobe <= 1'b0;
            if (expire) begin
                // Expiry wins over a byte arriving in the same cycle: that byte is lost.
                state      <= IDLE;
                tmo_cnt    <= '0;
                err_strobe <= 1'b1;
                err_code   <= ERR_TIMEOUT;
            end else begin
                if (rx_valid || !active) tmo_cnt <= '0;
                else                     tmo_cnt <= tmo_cnt + TMO_W'(1);

                unique case (state)
                    IDLE: begin
                        if (rx_valid) begin
                            opcode   <= rx_data;
                            byte_cnt <= '0;
                            state    <= TARGET;
                        end
                    end
                    TARGET: begin
                        if (rx_valid) begin
                            // First byte received ends up in target[7:0] after six shifts.
                            target   <= {rx_data, target[47:8]};
                            byte_cnt <= byte_cnt + 8'd1;
                            if (byte_cnt == 8'd5) state <= LENGTH;
                        end
                    end
                    LENGTH: begin
                        if (rx_valid) begin
                            len      <= rx_data;
                            byte_cnt <= '0;
                            if (rx_data == 8'd0) begin
                                cmd_opcode <= opcode;
                                cmd_target <= target;
                                cmd_len    <= 8'd0;
                                cmd_valid  <= 1'b1;
                                state      <= HOLD;
                            end else if (rx_data > MAX_LEN) begin
                                err_strobe <= 1'b1;
                                err_code   <= ERR_OVERSIZE;
                                state      <= DRAIN;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (rx_valid) begin
                            byte_cnt <= byte_cnt + 8'd1;
                            if (byte_cnt == len - 8'd1) begin
                                cmd_opcode <= opcode;
                                cmd_target <= target;
                                cmd_len    <= len;
                                cmd_valid  <= 1'b1;
                                state      <= HOLD;
                            end
                        end
                    end
                    DRAIN: begin
                        if (rx_valid) begin
                            byte_cnt <= byte_cnt + 8'd1;
                            if (byte_cnt == len - 8'd1) state <= IDLE;
                        end
                    end
                    HOLD: begin
                        // A byte here is never reinterpreted as an opcode, even alongside cmd_ack.
                        if (rx_valid) begin
                            err_strobe <= 1'b1;
                            err_code   <= ERR_OVERRUN;
                        end
                        if (cmd_ack) begin
                            cmd_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // NOTE: the payload buffer has no reset; its contents are never visible before a
    // frame rewrites them, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (state == PAYLOAD && rx_valid && !expire) begin
            pl_buf[byte_cnt[IDX_W-1:0]] <= rx_data;
        end
    end

    // NOTE: default assignment first so the combinational read cannot infer a latch.
    always_comb begin
        pl_data = 8'h00;
        if (pl_addr < cmd_len) pl_data = pl_buf[pl_addr[IDX_W-1:0]];
    end

endmodule

// File: tb/tb_host_cmd_frame_parser.sv
// Self-checking bench for host_cmd_frame_parser: directed corner cases plus randomized
// frames scored against a frame-level reference model.
module tb_host_cmd_frame_parser;

    localparam int MAX_PAYLOAD    = 16;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int MAX_GAP        = TIMEOUT_CYCLES - 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        cmd_valid;
    logic        cmd_ack = 1'b0;
    logic [7:0]  cmd_opcode;
    logic [47:0] cmd_target;
    logic [7:0]  cmd_len;
    logic [7:0]  pl_addr = 8'h00;
    logic [7:0]  pl_data;
    logic        err_strobe;
    logic [1:0]  err_code;

    host_cmd_frame_parser #(
        .MAX_PAYLOAD    (MAX_PAYLOAD),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cmd_valid  (cmd_valid),
        .cmd_ack    (cmd_ack),
        .cmd_opcode (cmd_opcode),
        .cmd_target (cmd_target),
        .cmd_len    (cmd_len),
        .pl_addr    (pl_addr),
        .pl_data    (pl_data),
        .err_strobe (err_strobe),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;

    // Reference frame and its serialized byte stream.
    logic [7:0]  cur_opcode;
    logic [47:0] cur_target;
    logic [7:0]  cur_len;
    logic [7:0]  cur_pl [256];
    logic [7:0]  bytes_q [$];

    // Every observed error pulse (one entry per strobe cycle) and the expected list.
    logic [1:0]  err_q [$];
    logic [1:0]  exp_err [$];

    always @(negedge clk) begin
        if (err_strobe === 1'b1) err_q.push_back(err_code);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    function automatic int pick_gap(input int max_gap);
        if (max_gap == 0) return 0;
        if ($urandom_range(0, 7) == 0) return max_gap;
        return $urandom_range(0, 3);
    endfunction

    task automatic build_bytes();
        bytes_q.delete();
        bytes_q.push_back(cur_opcode);
        for (int i = 0; i < 6; i++) bytes_q.push_back(cur_target[8*i +: 8]);
        bytes_q.push_back(cur_len);
        for (int i = 0; i < int'(cur_len); i++) bytes_q.push_back(cur_pl[i]);
    endtask

    task automatic make_frame(input int l);
        cur_opcode = 8'($urandom);
        cur_target = {16'($urandom), 32'($urandom)};
        cur_len    = 8'(l);
        for (int i = 0; i < l; i++) cur_pl[i] = 8'($urandom);
        build_bytes();
    endtask

    task automatic send_frame(input int max_gap, input bit good);
        for (int i = 0; i < bytes_q.size(); i++) begin
            if (good && i == bytes_q.size() - 1) check("valid_before_last", cmd_valid, 0);
            send_byte(bytes_q[i]);
            if (i < bytes_q.size() - 1) tick(pick_gap(max_gap));
        end
    endtask

    task automatic check_held(input string tag);
        check({tag, "_valid"},  cmd_valid,  1);
        check({tag, "_opcode"}, cmd_opcode, cur_opcode);
        check({tag, "_target"}, cmd_target, cur_target);
        check({tag, "_len"},    cmd_len,    cur_len);
        for (int i = 0; i <= int'(cur_len) + 1; i++) begin
            pl_addr = 8'(i);
            @(negedge clk);
            check({tag, "_pl_data"}, pl_data, (i < int'(cur_len)) ? cur_pl[i] : 8'h00);
        end
        pl_addr = 8'hFF;
        @(negedge clk);
        check({tag, "_pl_data_ff"}, pl_data, 8'h00);
        @(posedge clk);
        #1;
    endtask

    task automatic ack_frame(input string tag);
        cmd_ack = 1'b1;
        tick(1);
        cmd_ack = 1'b0;
        check({tag, "_valid_after_ack"}, cmd_valid, 0);
    endtask

    task automatic check_errs(input string tag);
        int n;
        tick(1);
        check({tag, "_err_count"}, err_q.size(), exp_err.size());
        n = (err_q.size() < exp_err.size()) ? err_q.size() : exp_err.size();
        for (int i = 0; i < n; i++) check({tag, "_err_code"}, err_q[i], exp_err[i]);
        err_q.delete();
        exp_err.delete();
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_valid",  cmd_valid,  0);
        check("rst_opcode", cmd_opcode, 0);
        check("rst_target", cmd_target, 0);
        check("rst_len",    cmd_len,    0);
        check("rst_strobe", err_strobe, 0);
        check("rst_code",   err_code,   0);
        check("rst_pl",     pl_data,    0);
        reset = 1'b1;
        tick(2);

        // Frame 01,FF x6,01,00 with cmd_ack toggled (ignored) while not holding
        cur_opcode = 8'h01;
        cur_target = 48'hFFFF_FFFF_FFFF;
        cur_len    = 8'd1;
        cur_pl[0]  = 8'h00;
        build_bytes();
        cmd_ack = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(bytes_q[i]);
        cmd_ack = 1'b0;
        for (int i = 4; i < bytes_q.size(); i++) begin
            if (i == bytes_q.size() - 1) check("t1_valid_before_last", cmd_valid, 0);
            send_byte(bytes_q[i]);
        end
        check_held("t1");
        ack_frame("t1");
        check_errs("t1");

        // L=0 frame held stable for 50 cycles
        cur_opcode = 8'h03;
        cur_target = 48'h6655_4433_2211;
        cur_len    = 8'd0;
        build_bytes();
        send_frame(0, 1'b1);
        check("t2_valid", cmd_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick(10);
            check("t2_hold_valid",  cmd_valid,  1);
            check("t2_hold_target", cmd_target, 48'h6655_4433_2211);
        end
        check_held("t2");
        ack_frame("t2");
        check_errs("t2");

        // Oversize L=20, drained, then a good frame
        make_frame(20);
        send_frame(0, 1'b0);
        exp_err.push_back(2'b01);
        check("t3_no_valid", cmd_valid, 0);
        check_errs("t3");
        make_frame(5);
        send_frame(0, 1'b1);
        check_held("t3_next");
        ack_frame("t3_next");

        // Timeout after opcode + 3 target bytes
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        tick(TIMEOUT_CYCLES - 1);
        check("t4_no_early_strobe", err_strobe, 0);
        tick(1);
        check("t4_strobe", err_strobe, 1);
        check("t4_code",   err_code,   2'b10);
        exp_err.push_back(2'b10);
        check_errs("t4");
        make_frame(3);
        send_frame(0, 1'b1);
        check_held("t4_next");
        ack_frame("t4_next");

        // Byte arriving in the expiry cycle is dropped
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        tick(TIMEOUT_CYCLES - 1);
        send_byte(8'hAA);
        check("t4b_strobe", err_strobe, 1);
        check("t4b_code",   err_code,   2'b10);
        exp_err.push_back(2'b10);
        check_errs("t4b");
        make_frame(2);
        send_frame(0, 1'b1);
        check_held("t4b_next");
        ack_frame("t4b_next");

        // Overrun while holding, including a byte coincident with cmd_ack
        make_frame(4);
        send_frame(0, 1'b1);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        exp_err.push_back(2'b11);
        exp_err.push_back(2'b11);
        check_errs("t5_hold");
        check_held("t5_hold");
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        cmd_ack  = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        cmd_ack  = 1'b0;
        check("t5_ack_valid", cmd_valid, 0);
        exp_err.push_back(2'b11);
        check_errs("t5_ack");
        make_frame(6);
        send_frame(0, 1'b1);
        check_held("t5_next");
        ack_frame("t5_next");

        // Reset during payload byte 3 (err_code still holds 11 from above)
        make_frame(8);
        for (int i = 0; i < 10; i++) send_byte(bytes_q[i]);
        pl_addr  = 8'h00;
        rx_data  = bytes_q[10];
        rx_valid = 1'b1;
        reset    = 1'b0;
        tick(1);
        rx_valid = 1'b0;
        check("t6_valid",  cmd_valid,  0);
        check("t6_opcode", cmd_opcode, 0);
        check("t6_target", cmd_target, 0);
        check("t6_len",    cmd_len,    0);
        check("t6_strobe", err_strobe, 0);
        check("t6_code",   err_code,   0);
        check("t6_pl",     pl_data,    0);
        tick(1);
        reset = 1'b1;
        tick(1);
        check_errs("t6");
        make_frame(MAX_PAYLOAD);
        send_frame(0, 1'b1);
        check_held("t6_next");

        // Reset while holding
        reset = 1'b0;
        tick(1);
        check("t6_hold_reset_valid", cmd_valid, 0);
        reset = 1'b1;
        tick(1);

        // Randomized frames with gaps up to the last accepted cycle before expiry
        for (int f = 0; f < 30; f++) begin
            int r;
            int l;
            r = $urandom_range(0, 9);
            if (r == 0)      l = 0;
            else if (r == 1) l = MAX_PAYLOAD;
            else if (r <= 3) l = $urandom_range(MAX_PAYLOAD + 1, 40);
            else             l = $urandom_range(1, MAX_PAYLOAD - 1);
            make_frame(l);
            if (l > MAX_PAYLOAD) begin
                send_frame(MAX_GAP, 1'b0);
                exp_err.push_back(2'b01);
                check("rnd_oversize_no_valid", cmd_valid, 0);
                check_errs("rnd_oversize");
            end else begin
                send_frame(MAX_GAP, 1'b1);
                check_held("rnd");
                tick($urandom_range(0, 8));
                check("rnd_still_valid", cmd_valid, 1);
                check_errs("rnd");
                ack_frame("rnd");
            end
        end

        check_errs("final");
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
